// File: rtl/ex_iter_divider_pkg.sv
// Shared definitions for the EX-stage iterative divider: ALU select codes for the
// RV32M divide group, FSM state encoding and small opcode decode helpers.
package ex_iter_divider_pkg;

    localparam logic [4:0] ALU_DIV  = 5'b01100;
    localparam logic [4:0] ALU_DIVU = 5'b01101;
    localparam logic [4:0] ALU_REM  = 5'b01110;
    localparam logic [4:0] ALU_REMU = 5'b01111;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CALC   = 2'd1;
    localparam logic [1:0] ST_FIX    = 2'd2;
    localparam logic [1:0] ST_FINISH = 2'd3;

    function automatic logic is_div_op(input logic [4:0] sel);
        return (sel == ALU_DIV) || (sel == ALU_DIVU) || (sel == ALU_REM) || (sel == ALU_REMU);
    endfunction

    function automatic logic is_signed_op(input logic [4:0] sel);
        return (sel == ALU_DIV) || (sel == ALU_REM);
    endfunction

    function automatic logic is_rem_op(input logic [4:0] sel);
        return (sel == ALU_REM) || (sel == ALU_REMU);
    endfunction

endpackage

// File: rtl/ex_iter_divider_div_restore_step.sv
// One combinational radix-2 restoring-division iteration on a {rem, quo} pair.
module div_restore_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH:0] rem_shift;
    logic [WIDTH:0] trial;
    logic           borrow;

    // rem_in < divisor keeps the shifted value below 2*divisor, so a WIDTH+1 bit
    // difference never wraps and its MSB is the borrow.
    assign rem_shift = {rem_in, quo_in[WIDTH-1]};
    assign trial     = rem_shift - {1'b0, divisor};
    assign borrow    = trial[WIDTH];

    assign rem_out = borrow ? rem_shift[WIDTH-1:0] : trial[WIDTH-1:0];
    assign quo_out = {quo_in[WIDTH-2:0], ~borrow};

endmodule

// File: rtl/ex_iter_divider.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU beside the EX-stage ALU.
// Optional macro DIV_EARLY_OUT_EN: skip the iterations when |divisor| > |dividend|.
module ex_iter_divider
    import ex_iter_divider_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [4:0]       SELECT,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    input  logic             FLUSH,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT
);

    localparam int               CW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]    LAST_ITER = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]       state_reg;
    logic [4:0]       op_reg;
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] quo_reg;
    logic [WIDTH-1:0] divisor_reg;
    logic [WIDTH-1:0] result_reg;
    logic [CW-1:0]    cnt_reg;
    logic             q_sign_reg;
    logic             r_sign_reg;

    logic             signed_op;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             div_zero;
    logic             overflow;
    logic             accept;
    logic             early_out;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    assign signed_op = is_signed_op(SELECT);
    assign a_neg     = signed_op & DATA1[WIDTH-1];
    assign b_neg     = signed_op & DATA2[WIDTH-1];
    assign a_mag     = a_neg ? ({WIDTH{1'b0}} - DATA1) : DATA1;
    assign b_mag     = b_neg ? ({WIDTH{1'b0}} - DATA2) : DATA2;
    assign div_zero  = (DATA2 == {WIDTH{1'b0}});
    assign overflow  = signed_op && (DATA1 == MIN_NEG) && (DATA2 == {WIDTH{1'b1}});
    assign accept    = (state_reg == ST_IDLE) && START && !FLUSH && is_div_op(SELECT);

`ifdef DIV_EARLY_OUT_EN
    assign early_out = (b_mag > a_mag);
`else
    assign early_out = 1'b0;
`endif

    div_restore_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem_in (rem_reg),
        .quo_in (quo_reg),
        .divisor(divisor_reg),
        .rem_out(step_rem),
        .quo_out(step_quo)
    );

    assign quo_fix = q_sign_reg ? ({WIDTH{1'b0}} - quo_reg) : quo_reg;
    assign rem_fix = r_sign_reg ? ({WIDTH{1'b0}} - rem_reg) : rem_reg;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_reg   <= ST_IDLE;
            op_reg      <= '0;
            rem_reg     <= '0;
            quo_reg     <= '0;
            divisor_reg <= '0;
            result_reg  <= '0;
            cnt_reg     <= '0;
            q_sign_reg  <= 1'b0;
            r_sign_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        op_reg      <= SELECT;
                        divisor_reg <= b_mag;
                        cnt_reg     <= '0;
                        // Short-cut cases preload the final quotient/remainder and
                        // let FIX register them, so DONE follows one edge later.
                        if (div_zero || overflow) begin
                            quo_reg    <= div_zero ? {WIDTH{1'b1}} : MIN_NEG;
                            rem_reg    <= div_zero ? DATA1 : {WIDTH{1'b0}};
                            q_sign_reg <= 1'b0;
                            r_sign_reg <= 1'b0;
                            state_reg  <= ST_FIX;
                        end else begin
                            quo_reg    <= early_out ? {WIDTH{1'b0}} : a_mag;
                            rem_reg    <= early_out ? a_mag : {WIDTH{1'b0}};
                            q_sign_reg <= a_neg ^ b_neg;
                            r_sign_reg <= a_neg;
                            state_reg  <= early_out ? ST_FIX : ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    if (FLUSH) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        rem_reg <= step_rem;
                        quo_reg <= step_quo;
                        cnt_reg <= cnt_reg + 1'b1;
                        if (cnt_reg == LAST_ITER) begin
                            state_reg <= ST_FIX;
                        end
                    end
                end
                ST_FIX: begin
                    if (FLUSH) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        result_reg <= is_rem_op(op_reg) ? rem_fix : quo_fix;
                        state_reg  <= ST_FINISH;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // A flush in the FINISH cycle must hide the pulse that is already up.
    assign DONE   = (state_reg == ST_FINISH) && !FLUSH;
    assign BUSY   = (state_reg != ST_IDLE);
    assign RESULT = result_reg;

endmodule

// File: tb/tb_ex_iter_divider.sv
// Directed-vector bench for ex_iter_divider: latency, results, flush, reset and ignore rules.
module tb_ex_iter_divider;
    import ex_iter_divider_pkg::*;

`ifdef DIV_EARLY_OUT_EN
    localparam int EARLY_LAT = 1;
`else
    localparam int EARLY_LAT = 33;
`endif

    logic        CLK    = 1'b0;
    logic        RESET  = 1'b0;
    logic        START  = 1'b0;
    logic [4:0]  SELECT = 5'd0;
    logic [31:0] DATA1  = 32'd0;
    logic [31:0] DATA2  = 32'd0;
    logic        FLUSH  = 1'b0;
    logic        BUSY;
    logic        DONE;
    logic [31:0] RESULT;

    int errors = 0;
    int checks = 0;

    ex_iter_divider #(.WIDTH(32)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .START (START),
        .SELECT(SELECT),
        .DATA1 (DATA1),
        .DATA2 (DATA2),
        .FLUSH (FLUSH),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .RESULT(RESULT)
    );

    always #5 CLK = ~CLK;

    // Issue one operation; lat = edges after the accepting edge until DONE is seen
    // (-1 on timeout), gap = BUSY low before DONE, tail = BUSY/DONE still up after.
    task automatic do_op(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] res, output logic gap,
                         output logic tail);
        @(negedge CLK);
        START = 1'b1; SELECT = sel; DATA1 = a; DATA2 = b;
        @(posedge CLK);
        @(negedge CLK);
        START = 1'b0; SELECT = 5'd0;
        lat = 0; gap = 1'b0; res = 32'hDEAD_BEEF;
        while (!DONE && lat < 100) begin
            if (!BUSY) gap = 1'b1;
            @(negedge CLK);
            lat++;
        end
        if (lat >= 100) begin
            lat = -1;
        end else begin
            res = RESULT;
            if (!BUSY) gap = 1'b1;
        end
        @(negedge CLK);
        tail = DONE | BUSY;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge CLK);
        $display("reset: BUSY=%0b DONE=%0b RESULT=%h", BUSY, DONE, RESULT);
        checks++;
        if ({BUSY, DONE, RESULT} !== 34'd0) begin
            errors++;
            $display("FAIL reset_state busy=%0b done=%0b result=%h required 0/0/0", BUSY, DONE, RESULT);
        end
        RESET = 1'b1;
    endtask

    task automatic test_divu_remu();
        logic [4:0]  sel [4] = '{ALU_DIVU, ALU_REMU, ALU_DIVU, ALU_REMU};
        logic [31:0] va  [4] = '{32'd100, 32'd100, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] vb  [4] = '{32'd7, 32'd7, 32'h8000_0001, 32'h8000_0001};
        logic [31:0] er  [4] = '{32'd14, 32'd2, 32'd1, 32'h7FFF_FFFE};
        int lat; logic [31:0] res; logic gap, tail;
        for (int i = 0; i < 4; i++) begin
            do_op(sel[i], va[i], vb[i], lat, res, gap, tail);
            $display("unsigned sel=%b %h/%h -> %h lat=%0d", sel[i], va[i], vb[i], res, lat);
            checks++;
            if (res !== er[i]) begin
                errors++; $display("FAIL unsigned_result[%0d] got=%h required=%h", i, res, er[i]);
            end
            checks++;
            if (lat != 33) begin
                errors++; $display("FAIL unsigned_latency[%0d] got=%0d required=33", i, lat);
            end
            checks++;
            if (gap || tail) begin
                errors++; $display("FAIL unsigned_busy[%0d] gap=%0b tail=%0b required 0/0", i, gap, tail);
            end
        end
    endtask

    task automatic test_signed();
        logic [4:0]  sel [4] = '{ALU_DIV, ALU_REM, ALU_REM, ALU_DIV};
        logic [31:0] va  [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd7};
        logic [31:0] vb  [4] = '{32'd2, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
        logic [31:0] er  [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFD};
        int lat; logic [31:0] res; logic gap, tail;
        for (int i = 0; i < 4; i++) begin
            do_op(sel[i], va[i], vb[i], lat, res, gap, tail);
            $display("signed sel=%b %h/%h -> %h lat=%0d", sel[i], va[i], vb[i], res, lat);
            checks++;
            if (res !== er[i]) begin
                errors++; $display("FAIL signed_result[%0d] got=%h required=%h", i, res, er[i]);
            end
            checks++;
            if (lat != 33 || gap || tail) begin
                errors++; $display("FAIL signed_timing[%0d] lat=%0d gap=%0b tail=%0b required 33/0/0", i, lat, gap, tail);
            end
        end
    endtask

    task automatic test_special();
        logic [4:0]  sel [5] = '{ALU_DIV, ALU_REMU, ALU_DIVU, ALU_DIV, ALU_REM};
        logic [31:0] va  [5] = '{32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] vb  [5] = '{32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] er  [5] = '{32'hFFFF_FFFF, 32'h1234_5678, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0};
        int lat; logic [31:0] res; logic gap, tail;
        for (int i = 0; i < 5; i++) begin
            do_op(sel[i], va[i], vb[i], lat, res, gap, tail);
            $display("special sel=%b %h/%h -> %h lat=%0d", sel[i], va[i], vb[i], res, lat);
            checks++;
            if (res !== er[i]) begin
                errors++; $display("FAIL special_result[%0d] got=%h required=%h", i, res, er[i]);
            end
            checks++;
            if (lat != 1 || gap || tail) begin
                errors++; $display("FAIL special_timing[%0d] lat=%0d gap=%0b tail=%0b required 1/0/0", i, lat, gap, tail);
            end
        end
    endtask

    task automatic test_early_out();
        logic [4:0]  sel [3] = '{ALU_DIVU, ALU_REM, ALU_DIV};
        logic [31:0] va  [3] = '{32'd3, 32'hFFFF_FFFD, 32'hFFFF_FFFD};
        logic [31:0] vb  [3] = '{32'd10, 32'd10, 32'd10};
        logic [31:0] er  [3] = '{32'd0, 32'hFFFF_FFFD, 32'd0};
        int lat; logic [31:0] res; logic gap, tail;
        for (int i = 0; i < 3; i++) begin
            do_op(sel[i], va[i], vb[i], lat, res, gap, tail);
            $display("small-dividend sel=%b %h/%h -> %h lat=%0d", sel[i], va[i], vb[i], res, lat);
            checks++;
            if (res !== er[i]) begin
                errors++; $display("FAIL early_result[%0d] got=%h required=%h", i, res, er[i]);
            end
            checks++;
            if (lat != EARLY_LAT || gap || tail) begin
                errors++; $display("FAIL early_timing[%0d] lat=%0d gap=%0b tail=%0b required %0d/0/0", i, lat, gap, tail, EARLY_LAT);
            end
        end
    endtask

    task automatic test_start_ignored();
        int lat = 0; logic [31:0] res = 32'hDEAD_BEEF;
        @(negedge CLK);
        START = 1'b1; SELECT = ALU_DIVU; DATA1 = 32'd100; DATA2 = 32'd7;
        @(posedge CLK);
        @(negedge CLK);
        // Keep START up with a different operation while the divide is in flight.
        SELECT = ALU_DIV; DATA1 = 32'hFFFF_FFF9; DATA2 = 32'd2;
        while (!DONE && lat < 100) begin
            if (lat == 20) START = 1'b0;
            @(negedge CLK);
            lat++;
        end
        if (lat < 100) res = RESULT;
        START = 1'b1;   // offered during FINISH: must be dropped
        @(negedge CLK);
        START = 1'b0;
        $display("start-while-busy: result=%h lat=%0d busy_after=%0b", res, lat, BUSY);
        checks++;
        if (res !== 32'd14 || lat != 33) begin
            errors++; $display("FAIL start_ignored got=%h lat=%0d required=0000000e lat=33", res, lat);
        end
        checks++;
        if (BUSY !== 1'b0) begin
            errors++; $display("FAIL start_in_finish busy=%0b required=0", BUSY);
        end
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_flush();
        int lat; logic [31:0] res; logic gap, tail; logic saw_done;
        do_op(ALU_DIVU, 32'd100, 32'd7, lat, res, gap, tail);
        checks++;
        if (res !== 32'd14) begin
            errors++; $display("FAIL flush_setup got=%h required=0000000e", res);
        end
        @(negedge CLK);
        START = 1'b1; SELECT = ALU_DIVU; DATA1 = 32'd1000; DATA2 = 32'd3;
        @(posedge CLK);
        @(negedge CLK);
        START = 1'b0;
        saw_done = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (DONE) saw_done = 1'b1;
            @(negedge CLK);
        end
        FLUSH = 1'b1;
        @(negedge CLK);
        FLUSH = 1'b0;
        $display("flush in CALC: busy=%0b done=%0b result=%h", BUSY, DONE, RESULT);
        checks++;
        if (BUSY !== 1'b0 || DONE !== 1'b0 || RESULT !== 32'd14) begin
            errors++; $display("FAIL flush_calc busy=%0b done=%0b result=%h required 0/0/0000000e", BUSY, DONE, RESULT);
        end
        for (int k = 0; k < 40; k++) begin
            if (DONE) saw_done = 1'b1;
            @(negedge CLK);
        end
        checks++;
        if (saw_done) begin
            errors++; $display("FAIL flush_no_done done_seen=1 required=0");
        end
        // Flush arriving in the FINISH cycle hides the pulse.
        @(negedge CLK);
        START = 1'b1; SELECT = ALU_DIVU; DATA1 = 32'd50; DATA2 = 32'd7;
        @(posedge CLK);
        @(negedge CLK);
        START = 1'b0;
        lat = 0;
        while (lat < 33) begin
            @(negedge CLK);
            lat++;
        end
        FLUSH = 1'b1;
        #1;
        $display("flush in FINISH: busy=%0b done=%0b", BUSY, DONE);
        checks++;
        if (DONE !== 1'b0 || BUSY !== 1'b1) begin
            errors++; $display("FAIL flush_finish done=%0b busy=%0b required 0/1", DONE, BUSY);
        end
        @(negedge CLK);
        FLUSH = 1'b0;
        checks++;
        if (BUSY !== 1'b0) begin
            errors++; $display("FAIL flush_finish_idle busy=%0b required=0", BUSY);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge CLK);
        START = 1'b1; SELECT = ALU_DIVU; DATA1 = 32'd1000; DATA2 = 32'd3;
        @(posedge CLK);
        @(negedge CLK);
        START = 1'b0;
        repeat (5) @(negedge CLK);
        RESET = 1'b0;
        #1;
        $display("reset mid-op: busy=%0b done=%0b result=%h", BUSY, DONE, RESULT);
        checks++;
        if (BUSY !== 1'b0 || DONE !== 1'b0 || RESULT !== 32'd0) begin
            errors++; $display("FAIL reset_mid busy=%0b done=%0b result=%h required 0/0/0", BUSY, DONE, RESULT);
        end
        @(negedge CLK);
        RESET = 1'b1;
    endtask

    task automatic test_bad_select();
        logic [4:0] sel [3] = '{5'b00000, 5'b01011, 5'b10000};
        logic active;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            START = 1'b1; SELECT = sel[i]; DATA1 = 32'd100; DATA2 = 32'd7;
            @(negedge CLK);
            START = 1'b0;
            active = 1'b0;
            for (int k = 0; k < 3; k++) begin
                if (BUSY || DONE) active = 1'b1;
                @(negedge CLK);
            end
            $display("ignored select=%b: activity=%0b", sel[i], active);
            checks++;
            if (active) begin
                errors++; $display("FAIL bad_select[%0d] busy_or_done=1 required=0", i);
            end
        end
    endtask

    initial begin
        test_reset();
        test_divu_remu();
        test_signed();
        test_special();
        test_early_out();
        test_start_ignored();
        test_flush();
        test_reset_mid();
        test_bad_select();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
